// File: rtl/link_rx_fifo_if.sv
// Link receive FIFO bus: the 4-phase req/ack write side, the
// first-word-fall-through read side, and the status outputs.
// The "master" modport is the environment, which is both the link master
// and the consumer. The "slave" modport is the FIFO itself.
interface link_rx_fifo_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              req;
  logic [DATA_W-1:0] data_in;
  logic              ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] checksum;

  modport master (
    output req, data_in, out_ready,
    input  ack, out_valid, out_data, count, checksum
  );

  modport slave (
    input  req, data_in, out_ready,
    output ack, out_valid, out_data, count, checksum
  );
endinterface

// File: rtl/link_rx_fifo.sv
// Link receive FIFO.
// A 4-phase req/ack handshake writes one byte per request into a
// DEPTH-entry FIFO. The head entry is presented first-word-fall-through.
// Reset is synchronous and active-low (rst).
// Optional feature: define LINK_RX_CHECKSUM_EN to keep a running XOR of
// every accepted byte. When the macro is undefined, checksum is tied to 0.
module link_rx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  link_rx_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACK_HI = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_write, do_pop;

  // Next-state and write-enable decode for the handshake FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d  = state_q;
    do_write = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The full check uses the registered count. A pop on the same
        // edge therefore never opens room for this write.
        if (bus.req && (count_q != DEPTH_C)) begin
          do_write = 1'b1;
          state_d  = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!bus.req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign do_pop = (count_q != '0) && bus.out_ready;

  // Handshake state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All flops then
    // sample pre-edge values, and no ordering race can occur between them.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Pointers and occupancy. Power-of-two depth makes the pointers wrap
  // naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_write, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    // NOTE: the array is not reset. count gates every read, so stale
    // entries are never visible, and a reset would only add a wide mux.
    if (do_write) mem[wr_ptr_q] <= bus.data_in;
  end

`ifdef LINK_RX_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  // Running XOR of accepted bytes. Only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst)          checksum_q <= '0;
    else if (do_write) checksum_q <= checksum_q ^ bus.data_in;
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

  assign bus.ack       = (state_q == ACK_HI);
  assign bus.count     = count_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = (count_q != '0) ? mem[rd_ptr_q] : '0;
endmodule

// File: tb/tb_link_rx_fifo.sv
// Directed testbench for link_rx_fifo (DEPTH=4, DATA_W=8).
module tb_link_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  link_rx_fifo_if #(.DEPTH(4), .DATA_W(8)) bus ();

  link_rx_fifo #(.DEPTH(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Inputs are driven, and outputs are sampled, 1 time unit after each
  // rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
    rst = 1'b0; step(); step();
    rst = 1'b1;
  endtask

  // One full handshake. The wait for ack is bounded.
  task automatic send(input logic [7:0] b);
    int n;
    bus.req = 1'b1; bus.data_in = b; n = 0;
    do begin step(); n++; end while (bus.ack !== 1'b1 && n < 20);
    checks++;
    if (bus.ack !== 1'b1) begin errors++; $display("FAIL send_ack_rise data=%h ack=%b want 1", b, bus.ack); end
    bus.req = 1'b0; step();
    checks++;
    if (bus.ack !== 1'b0) begin errors++; $display("FAIL send_ack_fall data=%h ack=%b want 0", b, bus.ack); end
  endtask

  task automatic test_reset();
    bus.req = 1'b1; bus.data_in = 8'h77; bus.out_ready = 1'b0;
    rst = 1'b0; step(); step();
    checks++; if (bus.ack !== 1'b0)       begin errors++; $display("FAIL reset_ack got %b want 0", bus.ack); end
    checks++; if (bus.count !== 3'd0)     begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.out_data); end
    checks++; if (bus.checksum !== 8'h00) begin errors++; $display("FAIL reset_checksum got %h want 00", bus.checksum); end
    bus.req = 1'b0; rst = 1'b1; step();
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 1'b1; bus.data_in = 8'hA5; step();
    checks++; if (bus.ack !== 1'b1)       begin errors++; $display("FAIL single_ack got %b want 1", bus.ack); end
    checks++; if (bus.count !== 3'd1)     begin errors++; $display("FAIL single_count got %0d want 1", bus.count); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", bus.out_data); end
    // Holding req high must not capture a second byte.
    step();
    checks++; if (bus.count !== 3'd1)     begin errors++; $display("FAIL single_no_dup got %0d want 1", bus.count); end
    bus.req = 1'b0; step();
    checks++; if (bus.ack !== 1'b0)       begin errors++; $display("FAIL single_ack_low got %b want 0", bus.ack); end
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    checks++; if (bus.count !== 3'd0)     begin errors++; $display("FAIL single_pop_count got %0d want 0", bus.count); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL single_empty_data got %h want 00", bus.out_data); end
    // A pop request on an empty FIFO is ignored.
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    checks++; if (bus.count !== 3'd0)     begin errors++; $display("FAIL single_empty_pop got %0d want 0", bus.count); end
  endtask

  task automatic test_fill();
    logic [7:0] exp_q [4];
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05};
    do_reset();
    for (int i = 1; i <= 4; i++) send(8'(i));
    checks++; if (bus.count !== 3'd4)     begin errors++; $display("FAIL fill_count got %0d want 4", bus.count); end
    checks++; if (bus.out_data !== 8'h01) begin errors++; $display("FAIL fill_head got %h want 01", bus.out_data); end
    bus.req = 1'b1; bus.data_in = 8'h05; step(); step();
    checks++; if (bus.ack !== 1'b0)       begin errors++; $display("FAIL fill_stall_ack got %b want 0", bus.ack); end
    checks++; if (bus.count !== 3'd4)     begin errors++; $display("FAIL fill_stall_count got %0d want 4", bus.count); end
    // A pop on the same edge does not let the stalled byte in.
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    checks++; if (bus.ack !== 1'b0)       begin errors++; $display("FAIL fill_no_bypass_ack got %b want 0", bus.ack); end
    checks++; if (bus.count !== 3'd3)     begin errors++; $display("FAIL fill_pop_count got %0d want 3", bus.count); end
    checks++; if (bus.out_data !== 8'h02) begin errors++; $display("FAIL fill_pop_head got %h want 02", bus.out_data); end
    step();
    checks++; if (bus.ack !== 1'b1)       begin errors++; $display("FAIL fill_capture_ack got %b want 1", bus.ack); end
    checks++; if (bus.count !== 3'd4)     begin errors++; $display("FAIL fill_capture_count got %0d want 4", bus.count); end
    bus.req = 1'b0; step();
`ifdef LINK_RX_CHECKSUM_EN
    checks++; if (bus.checksum !== 8'h01) begin errors++; $display("FAIL fill_checksum got %h want 01", bus.checksum); end
`else
    checks++; if (bus.checksum !== 8'h00) begin errors++; $display("FAIL fill_checksum got %h want 00", bus.checksum); end
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_data !== exp_q[i]) begin errors++; $display("FAIL fill_drain[%0d] got %h want %h", i, bus.out_data, exp_q[i]); end
      step();
    end
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fill_drained_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.req = 1'b1; bus.data_in = 8'h10 + 8'(i); step();
      checks++;
      if (bus.out_data !== 8'h10 + 8'(i) || bus.count !== 3'd1) begin
        errors++; $display("FAIL wrap_head[%0d] got %h/%0d want %h/1", i, bus.out_data, bus.count, 8'h10 + 8'(i));
      end
      bus.req = 1'b0; step();
      checks++;
      if (bus.count !== 3'd0) begin errors++; $display("FAIL wrap_count[%0d] got %0d want 0", i, bus.count); end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'h21); send(8'h22);
    bus.req = 1'b1; bus.data_in = 8'h23; bus.out_ready = 1'b1; step();
    bus.req = 1'b0; bus.out_ready = 1'b0;
    checks++; if (bus.count !== 3'd2)     begin errors++; $display("FAIL b2b_count got %0d want 2", bus.count); end
    checks++; if (bus.out_data !== 8'h22) begin errors++; $display("FAIL b2b_head got %h want 22", bus.out_data); end
    step();
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    checks++; if (bus.out_data !== 8'h23) begin errors++; $display("FAIL b2b_tail got %h want 23", bus.out_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 1'b1; bus.data_in = 8'h3C; step();
    checks++; if (bus.ack !== 1'b1)       begin errors++; $display("FAIL mid_ack got %b want 1", bus.ack); end
    rst = 1'b0; step();
    checks++; if (bus.ack !== 1'b0)       begin errors++; $display("FAIL mid_rst_ack got %b want 0", bus.ack); end
    checks++; if (bus.count !== 3'd0)     begin errors++; $display("FAIL mid_rst_count got %0d want 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.checksum !== 8'h00) begin errors++; $display("FAIL mid_rst_checksum got %h want 00", bus.checksum); end
    rst = 1'b1; step();
    checks++; if (bus.ack !== 1'b1)       begin errors++; $display("FAIL mid_recapture_ack got %b want 1", bus.ack); end
    checks++; if (bus.out_data !== 8'h3C) begin errors++; $display("FAIL mid_recapture_data got %h want 3c", bus.out_data); end
    bus.req = 1'b0; step();
  endtask

  task automatic test_checksum();
    do_reset();
    send(8'h0F);
`ifdef LINK_RX_CHECKSUM_EN
    checks++; if (bus.checksum !== 8'h0F) begin errors++; $display("FAIL csum_first got %h want 0f", bus.checksum); end
`else
    checks++; if (bus.checksum !== 8'h00) begin errors++; $display("FAIL csum_first got %h want 00", bus.checksum); end
`endif
    send(8'hF0); send(8'hFF);
    checks++; if (bus.checksum !== 8'h00) begin errors++; $display("FAIL csum_ff got %h want 00", bus.checksum); end
    do_reset();
    send(8'h12); send(8'h34);
`ifdef LINK_RX_CHECKSUM_EN
    checks++; if (bus.checksum !== 8'h26) begin errors++; $display("FAIL csum_26 got %h want 26", bus.checksum); end
`else
    checks++; if (bus.checksum !== 8'h00) begin errors++; $display("FAIL csum_26 got %h want 00", bus.checksum); end
`endif
  endtask

  initial begin
    bus.req = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_checksum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
